game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Parametrised game-flow controller for the dinorun family: sits between the VGA timer/LFSR and the
//  sprite modules, replacing single-shot HIT logic with lives, invulnerability, pause and N obstacle
//  channels. Latches per-pixel collisions over a frame, advances the game FSM once per frame and
//  drives score digits, spawn pulses and freeze/blink controls for the renderers.
// PARAMETERS
//  NUM_OBST       2   obstacle channels (1..16); channel k spawns when rand_i[15:12]==k
//  LIVES          3   lives per game (1..15)
//  INVULN_FRAMES  60  frames of invulnerability after a non-fatal hit (>=1)
//  MIN_GAP        30  minimum frames between two spawns (0 = no gap)
//  DIGITS         4   BCD score digits
// PORTS
//  clk_25_175_i        in   1            pixel clock
//  rst_ni              in   1            async active-low reset
//  next_frame_i        in   1            1-cycle pulse, once per frame
//  visible_i           in   1            pixel in visible area
//  start_i             in   1            start/acknowledge level
//  pause_i             in   1            pause button level (edge-detected internally)
//  rand_i              in   16           LFSR value
//  player_pixel_i      in   1            player sprite covers current pixel
//  obst_pixel_i        in   NUM_OBST     per-channel obstacle covers current pixel
//  obst_active_i       in   NUM_OBST     channel currently on screen
//  state_o             out  game_state_e current state
//  freeze_o            out  1            obstacles/player must not advance
//  blink_o             out  1            player blank phase during invulnerability
//  spawn_o             out  NUM_OBST     1-cycle spawn pulse, one-hot or zero
//  lives_o             out  4            lives remaining
//  score_o             out  4*DIGITS     BCD score, digit 0 in [3:0]
//  hiscore_o           out  4*DIGITS     BCD high score (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_ni=0): state TITLE, freeze_o=0, blink_o=0, spawn_o=0, lives_o=LIVES, score/hiscore 0,
//   hit latch, timers, gap counter and pause edge register cleared. Reset mid-game aborts immediately.
//  All outputs registered; FSM/lives/score update on the cycle after next_frame_i.
//  Hit latch: set on any cycle with visible_i & player_pixel_i & |obst_pixel_i while PLAYING; cleared
//   when next_frame_i consumes it. Collision on the next_frame_i cycle itself is included.
//  FSM (evaluated on next_frame_i except start/pause, evaluated every cycle):
//   TITLE:    start_i -> PLAYING; score<=0, lives<=LIVES, gap counter<=0.
//   PLAYING:  frame with hit: lives==1 -> GAMEOVER (lives<=0); else lives--, timer<=INVULN_FRAMES -> INVULN.
//             pause_i rising edge -> PAUSED. Hit and pause edge in same frame: hit wins, pause dropped.
//   INVULN:   collisions ignored; timer-- per frame; blink_o toggles every 4 frames; timer reaches 0 ->
//             PLAYING with blink_o=0. pause_i edge ignored.
//   PAUSED:   freeze_o=1; pause_i rising edge -> PLAYING; score, timers held.
//   GAMEOVER: freeze_o=1; start_i -> TITLE. start_i ignored in PLAYING/INVULN/PAUSED.
//  Score: +1 per frame in PLAYING/INVULN; BCD ripple carry; saturates at all-9s (no wrap).
//  Spawn: at next_frame_i in PLAYING/INVULN, gap counter==0, k=rand_i[15:12] < NUM_OBST and
//   obst_active_i[k]==0 -> spawn_o[k]=1 next cycle only, gap counter<=MIN_GAP; else no spawn.
//   Gap counter decrements per unfrozen frame, saturates at 0. Never more than one spawn per frame.
// CONFIGURATION
//  GAME_CTRL_HISCORE_EN defined: on entry to GAMEOVER, hiscore<=score if score>hiscore (BCD compare);
//   survives TITLE, cleared only by reset.
//  Undefined: no high-score register; hiscore_o tied to 0.
// STRUCTURE
//  dinorun_pkg: typedef enum game_state_e {TITLE, PLAYING, INVULN, PAUSED, GAMEOVER}; BLINK_PERIOD=4.
//  Sub-module bcd_counter #(DIGITS): clear, increment enable, saturate-at-max, BCD output.
// TESTING
//  1. Reset, start_i=1 one frame -> state PLAYING, lives_o=3, score increments 1/frame: 0000,0001,...
//  2. LIVES=3: collisions in 3 separate frames after invuln expires -> lives 2,1, then GAMEOVER, freeze_o=1.
//  3. Collision during INVULN (timer 60) -> lives unchanged; PLAYING after exactly 60 frames, blink_o=0.
//  4. pause_i pulse in PLAYING -> PAUSED, score frozen at e.g. 0042 over 10 frames; second pulse resumes 0043.
//  5. rand_i[15:12]=1, obst_active_i=2'b00, MIN_GAP=30 -> spawn_o=2'b10 one cycle; next 30 frames no spawn;
//     rand_i[15:12]=5 with NUM_OBST=2 -> no spawn.
//  6. GAME_CTRL_HISCORE_EN: game ending at 0123 then 0050 -> hiscore_o=0123; rst_ni low mid-game -> TITLE, all 0.

Source files
------------

// File: rtl/dinorun_pkg.sv
// Shared types and constants for the dinorun game-flow logic.
package dinorun_pkg;

    typedef enum logic [2:0] {
        TITLE,
        PLAYING,
        INVULN,
        PAUSED,
        GAMEOVER
    } game_state_e;

    // Frames per blink phase while the player is invulnerable.
    localparam int BLINK_PERIOD = 4;
    localparam int LIVES_W      = 4;

    function automatic logic is_running(input game_state_e s);
        return (s == PLAYING) || (s == INVULN);
    endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; holds at all-9s instead of wrapping.
module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count
);

    logic [4*DIGITS-1:0] count_next;
    logic                all_nines;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        count_next = count;
        all_nines  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (all_nines) begin
                if (count[4*d +: 4] == 4'd9) begin
                    count_next[4*d +: 4] = 4'd0;
                end else begin
                    count_next[4*d +: 4] = count[4*d +: 4] + 4'd1;
                    all_nines            = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !all_nines) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Dinorun game-flow controller: lives, invulnerability, pause, spawn arbitration and BCD score.
// Optional high-score register enabled by defining GAME_CTRL_HISCORE_EN.
module game_ctrl
    import dinorun_pkg::*;
#(
    parameter int NUM_OBST      = 2,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int MIN_GAP       = 30,
    parameter int DIGITS        = 4
) (
    input  logic                  clk_25_175_i,
    input  logic                  rst_ni,
    input  logic                  next_frame_i,
    input  logic                  visible_i,
    input  logic                  start_i,
    input  logic                  pause_i,
    input  logic [15:0]           rand_i,
    input  logic                  player_pixel_i,
    input  logic [NUM_OBST-1:0]   obst_pixel_i,
    input  logic [NUM_OBST-1:0]   obst_active_i,
    output game_state_e           state_o,
    output logic                  freeze_o,
    output logic                  blink_o,
    output logic [NUM_OBST-1:0]   spawn_o,
    output logic [LIVES_W-1:0]    lives_o,
    output logic [4*DIGITS-1:0]   score_o,
    output logic [4*DIGITS-1:0]   hiscore_o
);

    localparam int TIMER_W = $clog2(INVULN_FRAMES + 1);
    localparam int GAP_W   = $clog2(MIN_GAP + 2);
    localparam int BLINK_W = $clog2(BLINK_PERIOD);

    logic                hit_lat;
    logic                pause_prev;
    logic [TIMER_W-1:0]  timer;
    logic [BLINK_W-1:0]  blink_cnt;
    logic [GAP_W-1:0]    gap;
    logic [NUM_OBST-1:0] spawn_next;
    logic                running;
    logic                collide;
    logic                hit_now;
    logic                pause_edge;
    logic                game_start;

    assign running    = is_running(state_o);
    assign collide    = (state_o == PLAYING) && visible_i && player_pixel_i && (|obst_pixel_i);
    assign hit_now    = hit_lat | collide;
    assign pause_edge = pause_i & ~pause_prev;
    assign game_start = (state_o == TITLE) && start_i;

    // At most one channel matches the 4-bit selector, so the result is one-hot or zero.
    always_comb begin
        spawn_next = '0;
        if (next_frame_i && running && (gap == '0)) begin
            for (int i = 0; i < NUM_OBST; i++) begin
                if ((rand_i[15:12] == 4'(i)) && !obst_active_i[i]) begin
                    spawn_next[i] = 1'b1;
                end
            end
        end
    end

    bcd_counter #(.DIGITS(DIGITS)) u_score (
        .clk   (clk_25_175_i),
        .rst_n (rst_ni),
        .clear (game_start),
        .inc   (next_frame_i && running),
        .count (score_o)
    );

    always_ff @(posedge clk_25_175_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o    <= TITLE;
            freeze_o   <= 1'b0;
            blink_o    <= 1'b0;
            spawn_o    <= '0;
            lives_o    <= LIVES_W'(LIVES);
            hit_lat    <= 1'b0;
            timer      <= '0;
            blink_cnt  <= '0;
            gap        <= '0;
            pause_prev <= 1'b0;
        end else begin
            pause_prev <= pause_i;
            spawn_o    <= spawn_next;
            hit_lat    <= next_frame_i ? 1'b0 : hit_now;

            if (game_start) begin
                gap <= '0;
            end else if (next_frame_i) begin
                if (|spawn_next) begin
                    gap <= GAP_W'(MIN_GAP);
                end else if (!freeze_o && (gap != '0)) begin
                    gap <= gap - GAP_W'(1);
                end
            end

            case (state_o)
                TITLE: begin
                    if (start_i) begin
                        state_o <= PLAYING;
                        lives_o <= LIVES_W'(LIVES);
                    end
                end
                PLAYING: begin
                    // A hit already latched this frame blocks a pause request.
                    if (next_frame_i && hit_now) begin
                        if (lives_o == LIVES_W'(1)) begin
                            state_o  <= GAMEOVER;
                            lives_o  <= '0;
                            freeze_o <= 1'b1;
                        end else begin
                            state_o   <= INVULN;
                            lives_o   <= lives_o - LIVES_W'(1);
                            timer     <= TIMER_W'(INVULN_FRAMES);
                            blink_o   <= 1'b0;
                            blink_cnt <= '0;
                        end
                    end else if (pause_edge && !hit_now) begin
                        state_o  <= PAUSED;
                        freeze_o <= 1'b1;
                    end
                end
                INVULN: begin
                    if (next_frame_i) begin
                        if (timer == TIMER_W'(1)) begin
                            state_o <= PLAYING;
                            timer   <= '0;
                            blink_o <= 1'b0;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                            if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
                                blink_cnt <= '0;
                                blink_o   <= ~blink_o;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_W'(1);
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (pause_edge) begin
                        state_o  <= PLAYING;
                        freeze_o <= 1'b0;
                    end
                end
                GAMEOVER: begin
                    if (start_i) begin
                        state_o  <= TITLE;
                        freeze_o <= 1'b0;
                    end
                end
                default: begin
                    state_o  <= TITLE;
                    freeze_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    logic [4*DIGITS-1:0] hiscore_q;

    // Score is frozen in GAMEOVER, so comparing there captures the final score of the game.
    always_ff @(posedge clk_25_175_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hiscore_q <= '0;
        end else if ((state_o == GAMEOVER) && (score_o > hiscore_q)) begin
            hiscore_q <= score_o;
        end
    end

    assign hiscore_o = hiscore_q;
`else
    assign hiscore_o = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: per-cycle comparison against an integer-level game model plus literal checkpoints.
module tb_game_ctrl;
    import dinorun_pkg::*;

    localparam int NUM_OBST      = 2;
    localparam int LIVES         = 3;
    localparam int INVULN_FRAMES = 60;
    localparam int MIN_GAP       = 30;
    localparam int DIGITS        = 4;
    localparam int MAX_SCORE     = 9999;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  next_frame = 1'b0;
    logic                  visible = 1'b0;
    logic                  start = 1'b0;
    logic                  pause = 1'b0;
    logic [15:0]           rand_v = 16'hF000;
    logic                  player = 1'b0;
    logic [NUM_OBST-1:0]   obst_pixel = '0;
    logic [NUM_OBST-1:0]   obst_active = '0;
    game_state_e           state;
    logic                  freeze;
    logic                  blink;
    logic [NUM_OBST-1:0]   spawn;
    logic [3:0]            lives;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   hiscore;

    game_ctrl #(
        .NUM_OBST(NUM_OBST), .LIVES(LIVES), .INVULN_FRAMES(INVULN_FRAMES),
        .MIN_GAP(MIN_GAP), .DIGITS(DIGITS)
    ) dut (
        .clk_25_175_i   (clk),
        .rst_ni         (rst_n),
        .next_frame_i   (next_frame),
        .visible_i      (visible),
        .start_i        (start),
        .pause_i        (pause),
        .rand_i         (rand_v),
        .player_pixel_i (player),
        .obst_pixel_i   (obst_pixel),
        .obst_active_i  (obst_active),
        .state_o        (state),
        .freeze_o       (freeze),
        .blink_o        (blink),
        .spawn_o        (spawn),
        .lives_o        (lives),
        .score_o        (score),
        .hiscore_o      (hiscore)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_on  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int div;
        r   = '0;
        div = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    // Game model in plain integers: score as a number, invulnerability as frames left/elapsed.
    game_state_e         m_st;
    int                  m_score, m_hi, m_lives, m_inv_left, m_elapsed, m_gap;
    bit                  m_hit, m_pprev;
    logic [NUM_OBST-1:0] m_spawn;

    always @(posedge clk or negedge rst_n) begin : model
        game_state_e st;
        bit          hit, pedge, run;
        int          k;
        if (!rst_n) begin
            m_st = TITLE; m_score = 0; m_hi = 0; m_lives = LIVES;
            m_inv_left = 0; m_elapsed = 0; m_gap = 0;
            m_hit = 1'b0; m_pprev = 1'b0; m_spawn = '0;
        end else begin
            st    = m_st;
            run   = (st == PLAYING) || (st == INVULN);
            hit   = m_hit || ((st == PLAYING) && visible && player && (obst_pixel != '0));
            pedge = pause && !m_pprev;
            m_pprev = pause;
            m_hit   = !next_frame && hit;
            m_spawn = '0;
`ifdef GAME_CTRL_HISCORE_EN
            if (st == GAMEOVER && m_score > m_hi) m_hi = m_score;
`endif
            if (next_frame) begin
                k = int'(rand_v[15:12]);
                if (run && m_gap == 0 && k < NUM_OBST && ((obst_active >> k) & 1) == 0) begin
                    m_spawn = NUM_OBST'(1) << k;
                    m_gap   = MIN_GAP;
                end else if (st != PAUSED && st != GAMEOVER && m_gap > 0) begin
                    m_gap--;
                end
                if (run) m_score = (m_score < MAX_SCORE) ? m_score + 1 : MAX_SCORE;
            end
            case (st)
                TITLE:    if (start) begin m_st = PLAYING; m_score = 0; m_lives = LIVES; m_gap = 0; end
                PLAYING: begin
                    if (next_frame && hit) begin
                        if (m_lives == 1) begin
                            m_lives = 0; m_st = GAMEOVER;
                        end else begin
                            m_lives--; m_inv_left = INVULN_FRAMES; m_elapsed = 0; m_st = INVULN;
                        end
                    end else if (pedge && !hit) begin
                        m_st = PAUSED;
                    end
                end
                INVULN: if (next_frame) begin
                    m_inv_left--; m_elapsed++;
                    if (m_inv_left == 0) m_st = PLAYING;
                end
                PAUSED:   if (pedge) m_st = PLAYING;
                GAMEOVER: if (start) m_st = TITLE;
                default:  m_st = TITLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("state",   32'(state), 32'(m_st));
            check("freeze",  32'(freeze), 32'(m_st == PAUSED || m_st == GAMEOVER));
            check("blink",   32'(blink), 32'(m_st == INVULN && ((m_elapsed / BLINK_PERIOD) % 2) == 1));
            check("spawn",   32'(spawn), 32'(m_spawn));
            check("lives",   32'(lives), 32'(m_lives));
            check("score",   32'(score), 32'(to_bcd(m_score)));
            check("hiscore", 32'(hiscore), 32'(to_bcd(m_hi)));
        end
    end

    int                  spawn_cnt;
    logic [NUM_OBST-1:0] last_spawn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 of every frame carries an off-screen overlap that must never count as a hit.
    task automatic do_frames(input int n, input int hit_at, input int pause_at, input int flen);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < flen; c++) begin
                next_frame = (c == flen - 1);
                pause      = (c == pause_at);
                if (c == hit_at) begin
                    visible = 1'b1; player = 1'b1; obst_pixel = 2'b01;
                end else if (c == 0) begin
                    visible = 1'b0; player = 1'b1; obst_pixel = 2'b11;
                end else begin
                    visible = 1'b1; player = 1'b0; obst_pixel = 2'b10;
                end
                tick();
                if (spawn != '0) begin
                    spawn_cnt++;
                    last_spawn = spawn;
                end
            end
        end
        next_frame = 1'b0; pause = 1'b0; player = 1'b0; obst_pixel = '0;
    endtask

    task automatic frames(input int n);
        do_frames(n, -1, -1, 4);
    endtask

    logic [15:0] hi_a, hi_b;

    initial begin
`ifdef GAME_CTRL_HISCORE_EN
        hi_a = 16'h0126; hi_b = 16'h0123;
`else
        hi_a = 16'h0000; hi_b = 16'h0000;
`endif
        repeat (3) tick();
        check("rst_state", 32'(state), 32'(TITLE));
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'h0);
        check("rst_spawn", 32'(spawn), 32'h0);
        rst_n = 1'b1;
        tick();

        // Start and plain scoring
        start = 1'b1; tick(); start = 1'b0;
        check("start_state", 32'(state), 32'(PLAYING));
        check("start_lives", 32'(lives), 32'd3);
        frames(3);
        check("score_3", 32'(score), 32'h0003);

        // First hit, then a collision while invulnerable, blink phase and expiry
        do_frames(1, 1, -1, 4);
        check("hit1_state", 32'(state), 32'(INVULN));
        check("hit1_lives", 32'(lives), 32'd2);
        do_frames(1, 2, -1, 4);
        check("inv_hit_lives", 32'(lives), 32'd2);
        frames(3);
        check("blink_on", 32'(blink), 32'd1);
        frames(55);
        check("inv_59", 32'(state), 32'(INVULN));
        frames(1);
        check("inv_done", 32'(state), 32'(PLAYING));
        check("inv_done_blink", 32'(blink), 32'd0);
        check("score_64", 32'(score), 32'h0064);

        // Collision on the next_frame cycle itself, then the fatal hit
        do_frames(1, 3, -1, 4);
        check("hit2_lives", 32'(lives), 32'd1);
        frames(60);
        do_frames(1, 1, -1, 4);
        check("over_state", 32'(state), 32'(GAMEOVER));
        check("over_lives", 32'(lives), 32'd0);
        check("over_freeze", 32'(freeze), 32'd1);
        frames(2);
        check("over_score", 32'(score), 32'h0126);
        check("over_hiscore", 32'(hiscore), 32'(hi_a));

        // Restart, pause / resume
        start = 1'b1; tick();
        check("to_title", 32'(state), 32'(TITLE));
        tick(); start = 1'b0;
        check("restart_score", 32'(score), 32'h0);
        frames(42);
        do_frames(1, -1, 0, 4);
        check("paused", 32'(state), 32'(PAUSED));
        frames(10);
        check("paused_score", 32'(score), 32'h0042);
        do_frames(1, -1, 0, 4);
        check("resume_score", 32'(score), 32'h0043);

        // Hit and pause in one frame: hit wins; pause ignored while invulnerable
        do_frames(1, 1, 2, 4);
        check("hit_pause", 32'(state), 32'(INVULN));
        do_frames(1, -1, 1, 4);
        check("inv_pause", 32'(state), 32'(INVULN));
        frames(59);
        check("inv_exit2", 32'(state), 32'(PLAYING));

        // Spawn pulse, minimum gap, active-channel block, out-of-range selector
        rand_v = 16'h1000; spawn_cnt = 0;
        frames(1);
        check("spawn1_cnt", 32'(spawn_cnt), 32'd1);
        check("spawn1_val", 32'(last_spawn), 32'h2);
        spawn_cnt = 0; frames(30);
        check("gap_quiet", 32'(spawn_cnt), 32'd0);
        frames(1);
        check("gap_expired", 32'(spawn_cnt), 32'd1);
        obst_active = 2'b10; spawn_cnt = 0; frames(31);
        check("active_block", 32'(spawn_cnt), 32'd0);
        obst_active = 2'b00; rand_v = 16'h5000; frames(1);
        check("sel_range", 32'(spawn_cnt), 32'd0);
        rand_v = 16'h0ABC; frames(1);
        check("spawn0_val", 32'(last_spawn), 32'h1);
        rand_v = 16'hF000;

        // Reset mid-game aborts everything
        frames(2);
        rst_n = 1'b0; tick();
        check("mid_rst_state", 32'(state), 32'(TITLE));
        check("mid_rst_score", 32'(score), 32'h0);
        check("mid_rst_hi", 32'(hiscore), 32'h0);
        check("mid_rst_lives", 32'(lives), 32'd3);
        rst_n = 1'b1; tick();

        // Shortest possible game: ends at 0123
        start = 1'b1; tick(); start = 1'b0;
        do_frames(1, 1, -1, 4); frames(60);
        do_frames(1, 1, -1, 4); frames(60);
        do_frames(1, 1, -1, 4);
        tick();
        check("game2_score", 32'(score), 32'h0123);
        check("game2_hiscore", 32'(hiscore), 32'(hi_b));

        // Saturation at all nines, using short frames
        start = 1'b1; tick(); tick(); start = 1'b0;
        do_frames(10000, -1, -1, 2);
        check("saturate", 32'(score), 32'h9999);
        check("sat_hiscore", 32'(hiscore), 32'(hi_b));

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
